// File: rtl/xy_counter.sv
// Raster position counter: walks x across each line and y down each frame,
// counts completed frames and decodes the line/frame boundary strobes.
module xy_counter #(
    parameter int H_SIZE   = 640,
    parameter int V_SIZE   = 480,
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 9,
    parameter int F_WIDTH  = 8,
    parameter int ONE_SHOT = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic [F_WIDTH-1:0] frame_count,
    output logic               sol,
    output logic               eol,
    output logic               sof,
    output logic               eof,
    output logic               done
);

    if (H_SIZE < 2) begin : g_chk_h_size
        $error("xy_counter: H_SIZE must be at least 2");
    end
    if (V_SIZE < 2) begin : g_chk_v_size
        $error("xy_counter: V_SIZE must be at least 2");
    end
    if ((1 << X_WIDTH) < H_SIZE) begin : g_chk_x_width
        $error("xy_counter: X_WIDTH too narrow for H_SIZE");
    end
    if ((1 << Y_WIDTH) < V_SIZE) begin : g_chk_y_width
        $error("xy_counter: Y_WIDTH too narrow for V_SIZE");
    end

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_SIZE - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_SIZE - 1);

    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic [F_WIDTH-1:0] fc_q, fc_d;
    logic               done_q, done_d;
    logic               last_x, last_y;

    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        fc_d   = fc_q;
        done_d = done_q;
        // clear wins over enable and also releases a halted one-shot
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            done_d = 1'b0;
        end else if (enable && !done_q) begin
            if (!last_x) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                if (!last_y) begin
                    y_d = y_q + 1'b1;
                end else begin
                    y_d  = '0;
                    fc_d = fc_q + 1'b1;
                    if (ONE_SHOT != 0) begin
                        done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            fc_q   <= '0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            fc_q   <= fc_d;
            done_q <= done_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame_count = fc_q;
    assign done        = done_q;
    assign sol         = (x_q == '0);
    assign eol         = last_x;
    assign sof         = (x_q == '0) && (y_q == '0);
    assign eof         = last_x && last_y;

endmodule

// File: tb/tb_xy_counter.sv
// Directed bench for xy_counter on a 4x3 raster with a 2-bit frame counter,
// one free-running instance and one one-shot instance.
module tb_xy_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       enable1 = 1'b0;
    logic       clear1 = 1'b0;
    logic [1:0] x, y, fc, x1, y1, fc1;
    logic       sol, eol, sof, eof, done;
    logic       sol1, eol1, sof1, eof1, done1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xy_counter #(
        .H_SIZE(4), .V_SIZE(3), .X_WIDTH(2), .Y_WIDTH(2), .F_WIDTH(2), .ONE_SHOT(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .x(x), .y(y), .frame_count(fc),
        .sol(sol), .eol(eol), .sof(sof), .eof(eof), .done(done)
    );

    xy_counter #(
        .H_SIZE(4), .V_SIZE(3), .X_WIDTH(2), .Y_WIDTH(2), .F_WIDTH(2), .ONE_SHOT(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable1), .clear(clear1),
        .x(x1), .y(y1), .frame_count(fc1),
        .sol(sol1), .eol(eol1), .sof(sof1), .eof(eof1), .done(done1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey, input int efc);
        check({tag, ".x"}, int'(x), ex);
        check({tag, ".y"}, int'(y), ey);
        check({tag, ".fc"}, int'(fc), efc);
    endtask

    initial begin
        // asynchronous reset, no clock edge yet
        #2 reset_n = 1'b0;
        #1;
        check_pos("rst_async", 0, 0, 0);
        check("rst_done", int'(done), 0);
        check("rst_sol", int'(sol), 1);
        check("rst_sof", int'(sof), 1);
        check("rst_eol", int'(eol), 0);
        check("rst_eof", int'(eof), 0);

        // reset overrides enable and clear
        enable = 1'b1;
        clear = 1'b1;
        tick();
        tick();
        check_pos("rst_override", 0, 0, 0);
        clear = 1'b0;
        reset_n = 1'b1;

        // scenario 1: free run over one full frame
        for (int k = 0; k < 12; k++) begin
            check("s1.x", int'(x), k % 4);
            check("s1.y", int'(y), k / 4);
            check("s1.eof", int'(eof), (k == 11) ? 1 : 0);
            check("s1.sof", int'(sof), (k == 0) ? 1 : 0);
            check("s1.eol", int'(eol), (k % 4 == 3) ? 1 : 0);
            check("s1.fc", int'(fc), 0);
            tick();
        end
        check_pos("s1.end", 0, 0, 1);
        check("s1.done", int'(done), 0);

        // scenario 2: gated enable 1,0,1,0
        enable = 1'b1; tick();
        check_pos("s2.e1", 1, 0, 1);
        enable = 1'b0; tick();
        check_pos("s2.e0a", 1, 0, 1);
        check("s2.sol", int'(sol), 0);
        check("s2.eol", int'(eol), 0);
        enable = 1'b1; tick();
        check_pos("s2.e1b", 2, 0, 1);
        enable = 1'b0; tick(); tick();
        check_pos("s2.e0b", 2, 0, 1);
        check("s2.sof", int'(sof), 0);

        // scenario 3: frame_count wraps after four frames from a fresh reset
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        check_pos("s3.rst", 0, 0, 0);
        enable = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            repeat (12) tick();
            check_pos("s3.frame", 0, 0, f % 4);
            check("s3.sof", int'(sof), 1);
        end

        // scenario 4: clear at (2,1) with enable high, frame_count kept
        repeat (18) tick();
        check_pos("s4.pre", 2, 1, 1);
        clear = 1'b1;
        tick();
        check_pos("s4.clear", 0, 0, 1);
        clear = 1'b0;
        tick();
        check_pos("s4.resume", 1, 0, 1);

        // scenario 6: asynchronous reset mid-frame at (3,1), frame_count 2
        repeat (11) tick();
        repeat (7) tick();
        check_pos("s6.pre", 3, 1, 2);
        enable = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_pos("s6.async", 0, 0, 0);
        check("s6.sof", int'(sof), 1);
        check("s6.eof", int'(eof), 0);
        tick();
        reset_n = 1'b1;
        enable = 1'b1;
        tick();
        check_pos("s6.first", 1, 0, 0);
        enable = 1'b0;

        // scenario 5: one-shot instance halts after one frame
        check("s5.rst_x", int'(x1), 0);
        check("s5.rst_done", int'(done1), 0);
        enable1 = 1'b1;
        repeat (11) tick();
        check("s5.pre_eof", int'(eof1), 1);
        check("s5.pre_done", int'(done1), 0);
        tick();
        check("s5.done", int'(done1), 1);
        check("s5.x", int'(x1), 0);
        check("s5.y", int'(y1), 0);
        check("s5.fc", int'(fc1), 1);
        repeat (5) tick();
        check("s5.hold_done", int'(done1), 1);
        check("s5.hold_x", int'(x1), 0);
        check("s5.hold_fc", int'(fc1), 1);
        clear1 = 1'b1;
        tick();
        check("s5.clr_done", int'(done1), 0);
        check("s5.clr_x", int'(x1), 0);
        check("s5.clr_fc", int'(fc1), 1);
        clear1 = 1'b0;
        tick();
        check("s5.resume_x", int'(x1), 1);
        check("s5.resume_y", int'(y1), 0);
        enable1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xy_counter.md
XY_COUNTER -- requirements
Module: xy_counter

Interface
REQ-001 SHALL have parameter H_SIZE, default 640: pixels per line, at least 2.
REQ-002 SHALL have parameter V_SIZE, default 480: lines per frame, at least 2.
REQ-003 SHALL have parameter X_WIDTH, default 10: width of x, with 2**X_WIDTH >= H_SIZE.
REQ-004 SHALL have parameter Y_WIDTH, default 9: width of y, with 2**Y_WIDTH >= V_SIZE.
REQ-005 SHALL have parameter F_WIDTH, default 8: width of frame_count.
REQ-006 SHALL have parameter ONE_SHOT, default 0: 0 = free-running, 1 = halt after one frame.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1 bit: advance the position by one pixel this cycle.
REQ-010 SHALL have port clear, input, 1 bit: synchronous return to origin.
REQ-011 SHALL have port x, output, X_WIDTH bits: current column.
REQ-012 SHALL have port y, output, Y_WIDTH bits: current line.
REQ-013 SHALL have port frame_count, output, F_WIDTH bits: number of completed frames.
REQ-014 SHALL have ports sol, eol, sof, eof, output, 1 bit each: start/end-of-line and start/end-of-frame decode.
REQ-015 SHALL have port done, output, 1 bit: one-shot frame complete.

Function
REQ-016 x, y, frame_count and done SHALL be registers; sol, eol, sof and eof SHALL be combinational decodes of the current x and y.
REQ-017 sol SHALL equal (x==0), and eol SHALL equal (x==H_SIZE-1).
REQ-018 sof SHALL equal (x==0 && y==0), and eof SHALL equal (x==H_SIZE-1 && y==V_SIZE-1).
REQ-019 Advance condition: the counter SHALL advance when enable==1 && clear==0 && done==0.
REQ-020 On advance with x<H_SIZE-1: x SHALL become x+1 and y SHALL hold.
REQ-021 On advance with x==H_SIZE-1 and y<V_SIZE-1: x SHALL become 0 and y SHALL become y+1.
REQ-022 On advance at eof: x and y SHALL become 0 and frame_count SHALL increment, modulo 2**F_WIDTH.
REQ-023 On advance at eof with ONE_SHOT=1: done SHALL also become 1.
REQ-024 With ONE_SHOT=0, done SHALL be held at 0.
REQ-025 While done==1: x, y and frame_count SHALL hold regardless of enable.
REQ-026 clear==1 SHALL, on the next edge, set x=0, y=0 and done=0, keep frame_count unchanged, and take priority over enable.
REQ-027 enable==0 SHALL hold all registers; decode outputs SHALL follow the held values.
REQ-028 Latency: x and y SHALL reflect an advance on the edge where enable is sampled; there is no pipeline delay.
REQ-029 Values of x outside 0..H_SIZE-1 and of y outside 0..V_SIZE-1 SHALL be unreachable.
REQ-030 Parameter violations of REQ-001 to REQ-004 SHALL trigger an elaboration-time error.

Reset
REQ-031 When reset_n==0: x, y, frame_count and done SHALL be 0 immediately, without waiting for clk.
REQ-032 While reset_n==0: sol and sof SHALL be 1, and eol and eof SHALL be 0.
REQ-033 Reset SHALL override clear and enable.
REQ-034 Reset asserted mid-frame SHALL discard the position and the frame count.
REQ-035 The first advance after reset_n rises SHALL give x=1, y=0.

Verification (H_SIZE=4, V_SIZE=3, F_WIDTH=2)
REQ-036 Scenario 1, free run: reset, then enable held high for 12 cycles -> x sequence 0,1,2,3,0,...; y steps 0 to 1 to 2 to 0; eof high only at (3,2); frame_count 0 to 1 at cycle 12.
REQ-037 Scenario 2, gated enable: enable pattern 1,0,1,0 -> x 0, 1, 1, 2, 2; y stays 0; decodes stable while enable is low.
REQ-038 Scenario 3, frame_count wrap: 4 full frames (48 enabled cycles) -> frame_count 1,2,3,0; x=0, y=0, sof=1 after each frame.
REQ-039 Scenario 4, clear: clear with enable at (2,1) -> next edge (0,0); frame_count unchanged; enable ignored on that edge.
REQ-040 Scenario 5, ONE_SHOT=1: 12 enabled cycles -> done=1 and (0,0) with frame_count=1; 5 further enabled cycles -> no change; clear -> done=0 and counting resumes.
REQ-041 Scenario 6, asynchronous reset: reset_n low between clock edges at (3,1) with frame_count=2 -> x=0, y=0, frame_count=0 before the next edge; sof=1.
